baud_tick_gen: RTL and testbench

- Parametrised, runtime-programmable baud tick generator that replaces fixed-table clock gating with single-cycle tick enables.
- Fractional divisor (integer + FRAC_WIDTH-bit fraction) produces an oversample tick (rx_tick) for the UART receiver, a bit tick (tx_tick) for the transmitter, and a mid-bit sample strobe.
- Sits beside the UART Tx/Rx datapaths, which run on the system clock and qualify their state machines with these ticks.

---
 rtl/baud_tick_gen_if.sv | 26 ++
 rtl/baud_tick_gen.sv | 91 +++++++++
 tb/tb_baud_tick_gen.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/baud_tick_gen_if.sv
// Control and tick bundle between a UART datapath (master) and baud_tick_gen (slave).
interface baud_tick_gen_if #(
  parameter int unsigned DIV_WIDTH  = 16,
  parameter int unsigned FRAC_WIDTH = 4,
  parameter int unsigned OS_WIDTH   = 4
);
  logic                  enable;
  logic                  restart;
  logic                  cfg_load;
  logic [DIV_WIDTH-1:0]  cfg_div_int;
  logic [FRAC_WIDTH-1:0] cfg_div_frac;
  logic                  rx_tick;
  logic                  tx_tick;
  logic                  mid_tick;
  logic [OS_WIDTH-1:0]   os_count;

  modport master (
    output enable, restart, cfg_load, cfg_div_int, cfg_div_frac,
    input  rx_tick, tx_tick, mid_tick, os_count
  );

  modport slave (
    input  enable, restart, cfg_load, cfg_div_int, cfg_div_frac,
    output rx_tick, tx_tick, mid_tick, os_count
  );
endinterface

// File: rtl/baud_tick_gen.sv
// Fractional baud tick generator: oversample (rx), bit (tx) and mid-bit tick enables
// derived from a runtime-programmable integer + fraction divisor.
module baud_tick_gen #(
  parameter int unsigned DIV_WIDTH        = 16,
  parameter int unsigned FRAC_WIDTH       = 4,
  parameter int unsigned OVERSAMPLE       = 16,
  parameter int unsigned DEFAULT_DIV_INT  = 325,
  parameter int unsigned DEFAULT_DIV_FRAC = 8
) (
  input logic            clock,
  input logic            reset_n,
  baud_tick_gen_if.slave bus
);
  localparam int unsigned        OsWidth = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
  localparam logic [OsWidth-1:0] OsLast  = OsWidth'(OVERSAMPLE - 1);
  localparam logic [OsWidth-1:0] OsMid   = OsWidth'(OVERSAMPLE / 2 - 1);

  logic [DIV_WIDTH-1:0]  r_div_int;
  logic [FRAC_WIDTH-1:0] r_div_frac;
  logic [DIV_WIDTH-1:0]  r_pre;
  logic [FRAC_WIDTH-1:0] r_acc;
  logic                  r_ext;
  logic [OsWidth-1:0]    r_os;
  logic                  r_rx;
  logic                  r_tx;
  logic                  r_mid;

  logic [DIV_WIDTH-1:0]  w_div_eff;
  logic [DIV_WIDTH:0]    w_last;
  logic                  w_wrap;
  logic [FRAC_WIDTH:0]   w_acc_sum;
  logic                  w_rephase;

  always_comb begin
    w_div_eff = (r_div_int == '0) ? {{(DIV_WIDTH-1){1'b0}}, 1'b1} : r_div_int;
    // Terminal prescaler count is D-1, stretched by one when the last tick carried.
    w_last    = {1'b0, w_div_eff} - {{DIV_WIDTH{1'b0}}, 1'b1} + {{DIV_WIDTH{1'b0}}, r_ext};
    w_wrap    = ({1'b0, r_pre} == w_last);
    w_acc_sum = {1'b0, r_acc} + {1'b0, r_div_frac};
    w_rephase = bus.cfg_load | bus.restart | ~bus.enable;
  end

  // Divisor latches even while disabled so software can reprogram an idle port.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_div_int  <= DIV_WIDTH'(DEFAULT_DIV_INT);
      r_div_frac <= FRAC_WIDTH'(DEFAULT_DIV_FRAC);
    end else if (bus.cfg_load) begin
      r_div_int  <= bus.cfg_div_int;
      r_div_frac <= bus.cfg_div_frac;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_pre <= '0;
      r_acc <= '0;
      r_ext <= 1'b0;
      r_os  <= '0;
      r_rx  <= 1'b0;
      r_tx  <= 1'b0;
      r_mid <= 1'b0;
    end else if (w_rephase) begin
      r_pre <= '0;
      r_acc <= '0;
      r_ext <= 1'b0;
      r_os  <= '0;
      r_rx  <= 1'b0;
      r_tx  <= 1'b0;
      r_mid <= 1'b0;
    end else if (w_wrap) begin
      r_pre <= '0;
      r_acc <= w_acc_sum[FRAC_WIDTH-1:0];
      r_ext <= w_acc_sum[FRAC_WIDTH];
      r_os  <= r_os + OsWidth'(1);
      r_rx  <= 1'b1;
      r_tx  <= (r_os == OsLast);
      r_mid <= (r_os == OsMid);
    end else begin
      r_pre <= r_pre + DIV_WIDTH'(1);
      r_rx  <= 1'b0;
      r_tx  <= 1'b0;
      r_mid <= 1'b0;
    end
  end

  assign bus.rx_tick  = r_rx;
  assign bus.tx_tick  = r_tx;
  assign bus.mid_tick = r_mid;
  assign bus.os_count = r_os;
endmodule

// File: tb/tb_baud_tick_gen.sv
// Directed bench for baud_tick_gen: default-divisor instance (A) and OVERSAMPLE=4 instance (B).
module tb_baud_tick_gen;
  logic clock = 1'b0;
  logic reset_n;
  always #5 clock = ~clock;

  baud_tick_gen_if #(.DIV_WIDTH(16), .FRAC_WIDTH(4), .OS_WIDTH(4)) a_if ();
  baud_tick_gen_if #(.DIV_WIDTH(16), .FRAC_WIDTH(4), .OS_WIDTH(2)) b_if ();

  baud_tick_gen u_dut_a (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (a_if)
  );

  baud_tick_gen #(.OVERSAMPLE(4)) u_dut_b (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (b_if)
  );

  // Gaps packed one nibble per tick, index 0 = first gap counted from the cfg_load edge.
  typedef struct packed {
    logic [15:0]      div_int;
    logic [3:0]       div_frac;
    logic [0:7][3:0]  gaps;
  } vec_t;

  vec_t vecs [6];
  int   tests  = 0;
  int   failed = 0;
  int   stray  = 0;

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int get_rx(input bit sel);
    return sel ? int'(b_if.rx_tick) : int'(a_if.rx_tick);
  endfunction

  function automatic int get_tx(input bit sel);
    return sel ? int'(b_if.tx_tick) : int'(a_if.tx_tick);
  endfunction

  function automatic int get_mid(input bit sel);
    return sel ? int'(b_if.mid_tick) : int'(a_if.mid_tick);
  endfunction

  function automatic int get_os(input bit sel);
    return sel ? int'(b_if.os_count) : int'(a_if.os_count);
  endfunction

  // Counts edges until rx_tick is seen; gives up at limit (caller's compare then fails).
  task automatic wait_rx(input bit sel, input int limit, output int edges);
    edges = 0;
    forever begin
      step();
      edges++;
      if (get_rx(sel) == 1) break;
      if (get_tx(sel) != 0 || get_mid(sel) != 0) stray++;
      if (edges >= limit) break;
    end
  endtask

  task automatic load_b(input int di, input int df, input bit rst);
    b_if.cfg_div_int  = 16'(di);
    b_if.cfg_div_frac = 4'(df);
    b_if.cfg_load     = 1'b1;
    b_if.restart      = rst;
    step();
    b_if.cfg_load = 1'b0;
    b_if.restart  = 1'b0;
  endtask

  initial begin
    int edges;
    int n326;
    int tx_n;
    int tx_at;
    int mid_n;
    int mid_at;
    int hits;

    vecs[0] = '{16'd4, 4'd8,  32'h4454_5454};
    vecs[1] = '{16'd0, 4'd0,  32'h1111_1111};
    vecs[2] = '{16'd3, 4'd4,  32'h3333_4333};
    vecs[3] = '{16'd1, 4'd15, 32'h1122_2222};
    vecs[4] = '{16'd0, 4'd8,  32'h1121_2121};
    vecs[5] = '{16'd2, 4'd0,  32'h2222_2222};

    reset_n = 1'b0;
    a_if.enable = 1'b0; a_if.restart = 1'b0; a_if.cfg_load = 1'b0;
    a_if.cfg_div_int = '0; a_if.cfg_div_frac = '0;
    b_if.enable = 1'b0; b_if.restart = 1'b0; b_if.cfg_load = 1'b0;
    b_if.cfg_div_int = '0; b_if.cfg_div_frac = '0;
    repeat (3) step();

    for (int s = 0; s < 2; s++) begin
      check($sformatf("reset_rx%0d", s),  get_rx(s[0]),  0);
      check($sformatf("reset_tx%0d", s),  get_tx(s[0]),  0);
      check($sformatf("reset_mid%0d", s), get_mid(s[0]), 0);
      check($sformatf("reset_os%0d", s),  get_os(s[0]),  0);
    end

    // Default divisor 325 + 8/16 on instance A.
    a_if.enable = 1'b1;
    reset_n     = 1'b1;
    wait_rx(1'b0, 400, edges);
    check("a_first_tick", edges, 325);
    n326 = 0; tx_n = 0; tx_at = 0; mid_n = 0; mid_at = 0;
    for (int n = 1; n <= 17; n++) begin
      if (n > 1) begin
        wait_rx(1'b0, 700, edges);
        if (n <= 5) check($sformatf("a_gap%0d", n), edges, (n % 2 == 1) ? 326 : 325);
        if (edges == 326) n326++;
      end
      if (a_if.tx_tick) begin tx_n++; tx_at = n; end
      if (a_if.mid_tick) begin mid_n++; mid_at = n; end
    end
    check("a_long_gaps", n326, 8);
    check("a_tx_count", tx_n, 1);
    check("a_tx_index", tx_at, 16);
    check("a_mid_count", mid_n, 1);
    check("a_mid_index", mid_at, 8);
    check("a_os_tick17", int'(a_if.os_count), 1);
    a_if.enable = 1'b0;

    // Table of divisors on instance B (OVERSAMPLE=4).
    b_if.enable = 1'b1;
    for (int i = 0; i < 6; i++) begin
      load_b(int'(vecs[i].div_int), int'(vecs[i].div_frac), 1'b0);
      for (int k = 0; k < 8; k++) begin
        wait_rx(1'b1, 2 * int'(vecs[i].gaps[k]) + 10, edges);
        check($sformatf("v%0d_gap%0d", i, k), edges, int'(vecs[i].gaps[k]));
        check($sformatf("v%0d_tx%0d", i, k),  int'(b_if.tx_tick),  (k % 4 == 3) ? 1 : 0);
        check($sformatf("v%0d_mid%0d", i, k), int'(b_if.mid_tick), (k % 4 == 1) ? 1 : 0);
        check($sformatf("v%0d_os%0d", i, k),  int'(b_if.os_count), (k + 1) % 4);
      end
    end

    // cfg_load and restart together: new divisor wins.
    load_b(10, 0, 1'b1);
    check("both_os", int'(b_if.os_count), 0);
    check("both_rx", int'(b_if.rx_tick), 0);
    wait_rx(1'b1, 40, edges);
    check("both_first", edges, 10);

    // Restart two edges before a due tick; cfg_div_int change must not be latched.
    repeat (7) step();
    b_if.restart     = 1'b1;
    b_if.cfg_div_int = 16'd7;
    step();
    b_if.restart = 1'b0;
    check("restart_os", int'(b_if.os_count), 0);
    wait_rx(1'b1, 40, edges);
    check("restart_gap", edges, 10);

    // Disabled for 100 cycles; cfg_load still latches.
    b_if.enable      = 1'b0;
    b_if.cfg_div_int = 16'd5;
    hits = 0;
    for (int i = 0; i < 100; i++) begin
      b_if.cfg_load = (i == 50);
      step();
      if (b_if.rx_tick || b_if.tx_tick || b_if.mid_tick) hits++;
    end
    check("disabled_ticks", hits, 0);
    check("disabled_os", int'(b_if.os_count), 0);
    b_if.enable = 1'b1;
    wait_rx(1'b1, 30, edges);
    check("reenable_first", edges, 5);
    wait_rx(1'b1, 30, edges);
    check("reenable_gap", edges, 5);

    // Asynchronous reset while rx_tick is high.
    #1 reset_n = 1'b0;
    #1;
    check("areset_rx",  int'(b_if.rx_tick),  0);
    check("areset_tx",  int'(b_if.tx_tick),  0);
    check("areset_mid", int'(b_if.mid_tick), 0);
    check("areset_os",  int'(b_if.os_count), 0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    wait_rx(1'b1, 700, edges);
    check("areset_default_div", edges, 325);

    check("stray_ticks", stray, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule
